// File: rtl/uart_tx_fifo_eng_if.sv
// Write-side bus of the UART transmit engine: CPU write strobe and data in,
// FIFO status back to the CPU.
interface uart_tx_fifo_eng_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] OUT_PORT;
  logic              LOAD;
  logic              TXRDY;
  logic [CNT_W-1:0]  FIFO_CNT;
  logic              OVF;

  modport master (output OUT_PORT, LOAD, input TXRDY, FIFO_CNT, OVF);
  modport slave  (input OUT_PORT, LOAD, output TXRDY, FIFO_CNT, OVF);
endinterface

// File: rtl/uart_tx_fifo_eng.sv
// FIFO-buffered UART transmitter: start, LEN data bits LSB-first, optional
// parity, 1 or 2 stop bits; bit time is DIVISOR+1 clocks.
module uart_tx_fifo_eng #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 19
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [DIV_W-1:0]   DIVISOR,
  input  logic [3:0]         LEN,
  input  logic               PARITY_EN,
  input  logic               ODD_N_EVEN,
  input  logic               STOP2,
  uart_tx_fifo_eng_if.slave  bus,
  output logic               TX,
  output logic               BUSY
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // Everything a frame needs, captured at pop so config edits cannot tear a frame.
  typedef struct packed {
    logic [DATA_W-1:0] word;
    logic [3:0]        len;
    logic              par_en;
    logic              odd;
    logic              stop2;
    logic [DIV_W-1:0]  div;
  } frame_t;

  // ---------------- FIFO ----------------
  logic [FIFO_DEPTH-1:0][DATA_W-1:0] mem;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             txrdy_q, ovf_q;
  logic             full, push, pop;

  assign full  = (cnt == CNT_W'(FIFO_DEPTH));
  assign push  = bus.LOAD && !full;
  assign cnt_n = cnt + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= bus.OUT_PORT;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      txrdy_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      cnt     <= cnt_n;
      txrdy_q <= (cnt_n != CNT_W'(FIFO_DEPTH));
      // A full FIFO drops the write even when a pop frees a slot this cycle.
      ovf_q   <= bus.LOAD && full;
    end
  end

  assign bus.TXRDY    = txrdy_q;
  assign bus.FIFO_CNT = cnt;
  assign bus.OVF      = ovf_q;

  // ---------------- frame capture ----------------
  logic [3:0]        len_eff;
  logic [DATA_W:0]   len_onehot;
  logic [DATA_W-1:0] len_mask;
  frame_t            nxt_frm;

  always_comb begin
    len_eff    = (LEN >= 4'd5 && int'(LEN) <= DATA_W) ? LEN : 4'(DATA_W);
    len_onehot = {{DATA_W{1'b0}}, 1'b1} << len_eff;
    len_mask   = DATA_W'(len_onehot - {{DATA_W{1'b0}}, 1'b1});
    // Bits above LEN are zeroed here so neither TX nor parity can see them.
    nxt_frm.word   = mem[rd_ptr] & len_mask;
    nxt_frm.len    = len_eff;
    nxt_frm.par_en = PARITY_EN;
    nxt_frm.odd    = ODD_N_EVEN;
    nxt_frm.stop2  = STOP2;
    nxt_frm.div    = DIVISOR;
  end

  // ---------------- FSM ----------------
  state_t           state, state_n;
  frame_t           frm;
  logic [DIV_W-1:0] bt_cnt;
  logic [3:0]       bit_idx;
  logic             tick, last_data, last_stop, more;
  logic             tx_d, busy_d;
  logic [DATA_W-1:0] word_sh;

  assign tick      = (bt_cnt == frm.div);
  assign last_data = (bit_idx == frm.len - 4'd1);
  assign last_stop = !frm.stop2 || (bit_idx == 4'd1);
  assign more      = (cnt != '0);

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (more) state_n = S_START;
      S_START:  if (tick) state_n = S_DATA;
      S_DATA:   if (tick && last_data) state_n = frm.par_en ? S_PARITY : S_STOP;
      S_PARITY: if (tick) state_n = S_STOP;
      S_STOP:   if (tick && last_stop) state_n = more ? S_START : S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_comb begin
    pop     = 1'b0;
    tx_d    = 1'b1;
    word_sh = frm.word >> bit_idx;
    busy_d  = (state != S_IDLE) || more;
    case (state)
      S_IDLE:   pop  = more;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = word_sh[0];
      S_PARITY: tx_d = (^frm.word) ^ frm.odd;
      S_STOP: begin
        tx_d = 1'b1;
        pop  = tick && last_stop && more;
      end
      default:  tx_d = 1'b1;
    endcase
  end

  // Bit-time and bit-index counters; the index counts data bits and stop bits.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bt_cnt  <= '0;
      bit_idx <= '0;
      frm     <= '0;
    end else begin
      if (pop) frm <= nxt_frm;
      if (state == S_IDLE || tick) bt_cnt <= '0;
      else                         bt_cnt <= bt_cnt + DIV_W'(1);
      if (state_n != state)
        bit_idx <= '0;
      else if (tick && (state == S_DATA || state == S_STOP))
        bit_idx <= bit_idx + 4'd1;
    end
  end

  // TX and BUSY are registered together so BUSY drops right as the last stop bit ends.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      TX   <= 1'b1;
      BUSY <= 1'b0;
    end else begin
      TX   <= tx_d;
      BUSY <= busy_d;
    end
  end
endmodule
